// File: rtl/sys_reset_sequencer_pkg.sv
// Shared definitions for the system reset sequencer: FSM encoding,
// register map and cause-bit positions.
package sys_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    localparam logic [1:0] REG_STATUS  = 2'd0;
    localparam logic [1:0] REG_CONTROL = 2'd1;
    localparam logic [1:0] REG_CAUSE   = 2'd2;
    localparam logic [1:0] REG_COUNT   = 2'd3;

    localparam int CAUSE_PLL  = 0;
    localparam int CAUSE_EXT  = 1;
    localparam int CAUSE_SOFT = 2;
    localparam int CAUSE_W    = 3;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/reset_req_sync.sv
// Multi-flop synchronizer for an asynchronous reset request. It powers up
// reporting the request as present, so nothing is released until the input
// has been seen low for SYNC_STAGES clocks.
module reset_req_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic areset_n,
    input  logic req_async,
    output logic req_sync
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_async};
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign req_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sys_reset_sequencer.sv
// Staged reset generator: collapses PLL, board and soft requests into one
// request, then releases NUM_DOMAINS active-low resets in index order.
module sys_reset_sequencer
    import sys_reset_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS    = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   areset_n,
    input  logic                   pll_resetrequest,
    input  logic                   ext_reset_req,
    input  logic [1:0]             address,
    input  logic                   chipselect,
    input  logic                   write,
    input  logic                   read,
    input  logic [15:0]            writedata,
    output logic [15:0]            readdata,
    output logic [NUM_DOMAINS-1:0] reset_n_out,
    output logic                   ready
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int STAG_W = $clog2(STAGGER_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);

    logic pll_sync;
    logic ext_sync;
    logic soft_pulse;
    logic cause_w1c;
    logic req;
    logic unused_bus;

    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [STAG_W-1:0]      stag_cnt_q, stag_cnt_d;
    logic [NUM_DOMAINS-1:0] reset_n_out_q, reset_n_out_d;
    logic                   ready_q, ready_d;
    logic [CAUSE_W-1:0]     cause_q, cause_d, cause_set;
    logic [15:0]            rst_count_q, rst_count_d;

    reset_req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pll_sync (
        .clk       (clk),
        .areset_n  (areset_n),
        .req_async (pll_resetrequest),
        .req_sync  (pll_sync)
    );

    reset_req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
        .clk       (clk),
        .areset_n  (areset_n),
        .req_async (ext_reset_req),
        .req_sync  (ext_sync)
    );

    assign soft_pulse = chipselect & write & (address == REG_CONTROL) & writedata[0];
    assign cause_w1c  = chipselect & write & (address == REG_CAUSE);
    assign req        = pll_sync | ext_sync | soft_pulse;
    assign unused_bus = ^{read, writedata[15:CAUSE_W]};

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        stag_cnt_d    = stag_cnt_q;
        reset_n_out_d = reset_n_out_q;
        ready_d       = ready_q;
        rst_count_d   = rst_count_q;

        if (req) begin
            state_d       = ST_RESET;
            hold_cnt_d    = '0;
            stag_cnt_d    = '0;
            reset_n_out_d = '0;
            ready_d       = 1'b0;
            if (state_q == ST_RUN && rst_count_q != COUNT_MAX) begin
                rst_count_d = rst_count_q + 16'd1;
            end
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d       = ST_RELEASE;
                        stag_cnt_d    = '0;
                        reset_n_out_d = NUM_DOMAINS'(1);
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // Thermometer shift: bits can only ever rise in index order.
                    if (&reset_n_out_q) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else if (stag_cnt_q == STAG_LAST) begin
                        stag_cnt_d    = '0;
                        reset_n_out_d = (reset_n_out_q << 1) | NUM_DOMAINS'(1);
                    end else begin
                        stag_cnt_d = stag_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    // New sightings of a source win over a same-cycle clear.
    always_comb begin
        cause_set             = '0;
        cause_set[CAUSE_PLL]  = pll_sync;
        cause_set[CAUSE_EXT]  = ext_sync;
        cause_set[CAUSE_SOFT] = soft_pulse;
        cause_d = cause_w1c ? (cause_q & ~writedata[CAUSE_W-1:0]) : cause_q;
        cause_d = cause_d | cause_set;
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q       <= ST_RESET;
            hold_cnt_q    <= '0;
            stag_cnt_q    <= '0;
            reset_n_out_q <= '0;
            ready_q       <= 1'b0;
            cause_q       <= '0;
            rst_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            stag_cnt_q    <= stag_cnt_d;
            reset_n_out_q <= reset_n_out_d;
            ready_q       <= ready_d;
            cause_q       <= cause_d;
            rst_count_q   <= rst_count_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            REG_STATUS: begin
                readdata[0]                = ready_q;
                readdata[2:1]              = state_q;
                readdata[8 +: NUM_DOMAINS] = reset_n_out_q;
            end
            REG_CAUSE: readdata[CAUSE_W-1:0] = cause_q;
            REG_COUNT: readdata              = rst_count_q;
            default:   readdata              = '0;
        endcase
    end

    assign reset_n_out = reset_n_out_q;
    assign ready       = ready_q;

endmodule

// File: tb/tb_sys_reset_sequencer.sv
// Bench for sys_reset_sequencer: output edges are scoreboarded against
// expected (cycle, value) events; register reads are checked directly.
module tb_sys_reset_sequencer;
    import sys_reset_sequencer_pkg::*;

    localparam int N    = 3;
    localparam int SYNC = 2;
    localparam int HOLD = 16;
    localparam int STAG = 8;

    logic          clk = 1'b0;
    logic          areset_n = 1'b0;
    logic          pll_resetrequest = 1'b0;
    logic          ext_reset_req = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          chipselect = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [15:0]   writedata = 16'd0;
    logic [15:0]   readdata;
    logic [N-1:0]  reset_n_out;
    logic          ready;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        int         cyc;
        logic [N:0] val;
    } ev_t;
    ev_t sb_q[$];

    sys_reset_sequencer #(
        .NUM_DOMAINS    (N),
        .SYNC_STAGES    (SYNC),
        .HOLD_CYCLES    (HOLD),
        .STAGGER_CYCLES (STAG)
    ) dut (
        .clk              (clk),
        .areset_n         (areset_n),
        .pll_resetrequest (pll_resetrequest),
        .ext_reset_req    (ext_reset_req),
        .address          (address),
        .chipselect       (chipselect),
        .write            (write),
        .read             (read),
        .writedata        (writedata),
        .readdata         (readdata),
        .reset_n_out      (reset_n_out),
        .ready            (ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input string tag, input int c, input logic [N:0] v);
        ev_t e;
        e.tag = tag;
        e.cyc = c;
        e.val = v;
        sb_q.push_back(e);
    endtask

    // Release i lands on edge t0+HOLD+i*STAG; ready one edge after the last.
    task automatic push_seq(input string tag, input int t0, input int nrel, input bit with_ready);
        logic [N:0] v;
        v = '0;
        for (int i = 0; i < nrel; i++) begin
            v[i] = 1'b1;
            push_ev($sformatf("%s_rel%0d", tag, i), t0 + HOLD + i * STAG, v);
        end
        if (with_ready) begin
            v[N] = 1'b1;
            push_ev({tag, "_rdy"}, t0 + HOLD + (N - 1) * STAG + 1, v);
        end
    endtask

    function automatic int run_done(input int t0);
        return t0 + HOLD + (N - 1) * STAG + 1;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [1:0] a, input logic [15:0] exp);
        address    = a;
        chipselect = 1'b1;
        read       = 1'b1;
        #1;
        check(tag, {16'd0, readdata}, {16'd0, exp});
        chipselect = 1'b0;
        read       = 1'b0;
    endtask

    task automatic soft_reset(input string tag, output int t0, input int nrel, input bit with_ready);
        int w;
        w = cyc;
        push_ev({tag, "_drop"}, w + 1, '0);
        bus_write(REG_CONTROL, 16'h0001);
        t0 = w + 2;
        push_seq(tag, t0, nrel, with_ready);
    endtask

    // Output monitor: every change of {ready, reset_n_out} must match the next event.
    initial begin
        logic [N:0] prev;
        logic [N:0] now;
        ev_t        e;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            now = {ready, reset_n_out};
            if (now !== prev) begin
                if (sb_q.size() == 0) begin
                    check("unexp_chg", 32'(now), 32'(prev));
                end else begin
                    e = sb_q.pop_front();
                    check({e.tag, "_val"}, 32'(now), 32'(e.val));
                    check({e.tag, "_cyc"}, cyc, e.cyc);
                end
                prev = now;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t0, p, e, a, r;

        repeat (3) @(negedge clk);
        check("por_out", 32'(reset_n_out), 0);
        check("por_rdy", 32'(ready), 0);
        bus_read("por_status", REG_STATUS, 16'h0000);
        bus_read("por_cause", REG_CAUSE, 16'h0000);
        bus_read("por_count", REG_COUNT, 16'h0000);

        // Power-up release with both requests low.
        r  = cyc;
        t0 = r + SYNC + 1;
        push_seq("pwr", t0, N, 1'b1);
        areset_n = 1'b1;
        wait_until(t0 - 1);
        bus_read("pwr_still_rst", REG_STATUS, 16'h0000);
        wait_until(t0);
        bus_read("pwr_hold", REG_STATUS, 16'h0002);
        wait_until(run_done(t0));
        bus_read("pwr_status", REG_STATUS, 16'h0707);
        bus_read("pwr_count", REG_COUNT, 16'h0000);

        // Writes that must not disturb anything.
        bus_write(REG_CONTROL, 16'hFFFE);
        bus_write(REG_STATUS, 16'h0001);
        bus_write(REG_COUNT, 16'hFFFF);
        bus_read("ctl_rd", REG_CONTROL, 16'h0000);
        bus_read("noop_status", REG_STATUS, 16'h0707);
        bus_read("noop_count", REG_COUNT, 16'h0000);
        bus_write(REG_CAUSE, 16'h0007);
        bus_read("cause_clr", REG_CAUSE, 16'h0000);

        // PLL request pulse (3 cycles) while running.
        p = cyc;
        push_ev("pll_drop", p + SYNC + 1, '0);
        pll_resetrequest = 1'b1;
        repeat (3) @(negedge clk);
        pll_resetrequest = 1'b0;
        bus_read("pll_cause", REG_CAUSE, 16'h0001);
        bus_read("pll_count", REG_COUNT, 16'h0001);
        t0 = cyc + SYNC + 1;
        push_seq("pll", t0, 1, 1'b0);

        // External request after domain 0 is out of reset.
        wait_until(t0 + 20);
        e = cyc;
        push_ev("ext_drop", e + SYNC + 1, '0);
        ext_reset_req = 1'b1;
        repeat (4) @(negedge clk);
        ext_reset_req = 1'b0;
        bus_read("ext_cause", REG_CAUSE, 16'h0003);
        bus_write(REG_CAUSE, 16'h0002);
        bus_read("ext_setwins", REG_CAUSE, 16'h0003);
        @(negedge clk);
        bus_write(REG_CAUSE, 16'h0003);
        bus_read("ext_w1c", REG_CAUSE, 16'h0000);
        bus_read("ext_count", REG_COUNT, 16'h0001);
        t0 = e + 4 + SYNC + 1;
        push_seq("ext", t0, N, 1'b1);
        wait_until(run_done(t0));
        bus_read("ext_status", REG_STATUS, 16'h0707);

        // Soft reset through the control register.
        soft_reset("soft", t0, N, 1'b1);
        bus_read("soft_status", REG_STATUS, 16'h0000);
        bus_read("soft_cause", REG_CAUSE, 16'h0004);
        bus_read("soft_ctl", REG_CONTROL, 16'h0000);
        bus_read("soft_count", REG_COUNT, 16'h0002);
        bus_write(REG_CAUSE, 16'h0004);
        bus_read("soft_w1c", REG_CAUSE, 16'h0000);
        wait_until(run_done(t0));

        // Counter saturation, preloaded one below the top.
        force dut.rst_count_d = 16'hFFFE;
        @(negedge clk);
        release dut.rst_count_d;
        bus_read("sat_pre", REG_COUNT, 16'hFFFE);
        soft_reset("sat1", t0, N, 1'b1);
        bus_read("sat_max", REG_COUNT, 16'hFFFF);
        wait_until(run_done(t0));
        soft_reset("sat2", t0, 2, 1'b0);
        bus_read("sat_hold", REG_COUNT, 16'hFFFF);

        // Asynchronous reset in the middle of the release phase.
        wait_until(t0 + HOLD + STAG + 2);
        a = cyc;
        push_ev("arst_drop", a + 1, '0);
        areset_n = 1'b0;
        #1;
        check("arst_out", 32'(reset_n_out), 0);
        check("arst_rdy", 32'(ready), 0);
        bus_read("arst_status", REG_STATUS, 16'h0000);
        bus_read("arst_cause", REG_CAUSE, 16'h0000);
        bus_read("arst_count", REG_COUNT, 16'h0000);
        repeat (2) @(negedge clk);
        r  = cyc;
        t0 = r + SYNC + 1;
        push_seq("rearm", t0, N, 1'b1);
        areset_n = 1'b1;
        wait_until(run_done(t0));
        bus_read("rearm_status", REG_STATUS, 16'h0707);
        bus_read("rearm_count", REG_COUNT, 16'h0000);

        repeat (3) @(negedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
